// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one FP32 adder among NUM_REQ requesters.
// Issue-order tag FIFO routes each adder result back to its issuer.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_a/req_b/req_valid      per-requester operand pairs (32-bit slices)
//   req_ready                  one-hot request acceptance
//   add_a/add_b/add_valid      operand pair toward the shared adder
//   add_ready                  adder accepts the operand pair
//   add_c/add_c_valid          adder result in issue order
//   add_c_ready                result accepted by the addressed requester
//   res_c/res_valid            broadcast result, one-hot valid
//   res_ready                  per-requester result acceptance
//   busy/outstanding           occupancy of the tag FIFO
//
// Build option: FP_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.

module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [32*NUM_REQ-1:0]      req_a,
    input  logic [32*NUM_REQ-1:0]      req_b,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [31:0]                add_a,
    output logic [31:0]                add_b,
    output logic                       add_valid,
    input  logic                       add_ready,
    input  logic [31:0]                add_c,
    input  logic                       add_c_valid,
    output logic                       add_c_ready,
    output logic [31:0]                res_c,
    output logic [NUM_REQ-1:0]         res_valid,
    input  logic [NUM_REQ-1:0]         res_ready,
    output logic                       busy,
    output logic [$clog2(MAX_OUT):0]   outstanding
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUT);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] tag_q [MAX_OUT];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [IDW-1:0] gid;
    logic [IDW-1:0] head;
    logic           any_req;
    logic           full;
    logic           empty;
    logic           issue;
    logic           retire;

    assign any_req = |req_valid;
    assign full    = (cnt_q == CW'(MAX_OUT));
    assign empty   = (cnt_q == '0);
    assign head    = tag_q[rptr_q];

`ifdef FP_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest valid index.
    always_comb begin
        gid = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gid = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_q, rr_d;

    // Descending offset scan: the last hit is the nearest
    // valid requester at or after rr_q.
    always_comb begin
        int idx;
        gid = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                gid = IDW'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            if (gid == IDW'(NUM_REQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gid + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // rst_n gates the combinational handshakes so nothing is
    // offered to the adder while reset is held.
    assign add_valid = rst_n & any_req & ~full;
    assign issue     = add_valid & add_ready;
    assign add_a     = req_a[32*int'(gid) +: 32];
    assign add_b     = req_b[32*int'(gid) +: 32];

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[gid] = 1'b1;
        end
    end

    // Results with no tag in flight are ignored.
    assign add_c_ready = ~empty & res_ready[head];
    assign retire      = add_c_valid & add_c_ready;
    assign res_c       = add_c;

    always_comb begin
        res_valid = '0;
        if (add_c_valid && !empty) begin
            res_valid[head] = 1'b1;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (issue) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (retire) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({issue, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (issue) begin
                tag_q[wptr_q] <= gid;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign outstanding = cnt_q;
    assign busy        = ~empty;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: vector table, directed corner sequences and
// random traffic against a queue-based reference model.

module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int M   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_valid, req_ready;
    logic [31:0]     add_a, add_b, add_c, res_c;
    logic            add_valid, add_ready, add_c_valid, add_c_ready;
    logic [N-1:0]    res_valid, res_ready;
    logic            busy;
    logic [2:0]      outstanding;

    always #5 clk = ~clk;

    fp_add_arbiter #(.NUM_REQ(N), .MAX_OUT(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b),
        .add_valid(add_valid), .add_ready(add_ready),
        .add_c(add_c), .add_c_valid(add_c_valid),
        .add_c_ready(add_c_ready),
        .res_c(res_c), .res_valid(res_valid),
        .res_ready(res_ready),
        .busy(busy), .outstanding(outstanding)
    );

    typedef struct {
        logic [31:0] r;
        int          t;
    } aop_t;

    typedef struct {
        logic [N-1:0] v;
        logic         ar;
        logic         spur;
        logic [N-1:0] e_rr;
        logic         e_av;
        logic         e_cr;
        logic [N-1:0] e_rv;
        int           e_out;
    } vec_t;

    aop_t        aq[$];
    int          tagq[$];
    logic [31:0] resq[$];
    int          rr;
    int          cyc;
    int          checks, errors;
    bit          stall, spur;

    logic [N-1:0] s_rr, s_rv;
    logic         s_av, s_cr, s_busy;
    logic [2:0]   s_out;
    logic [31:0]  s_rc;
    int           s_iss;

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Positive normal FP32 add, truncating; stands in for the adder.
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        logic [31:0] t;
        logic [24:0] ma, mb, s;
        logic [7:0]  e;
        int          d;
        if (a[30:23] < b[30:23]) begin
            t = a; a = b; b = t;
        end
        d  = int'(a[30:23]) - int'(b[30:23]);
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]} >> d;
        s  = ma + mb;
        e  = a[30:23];
        if (s[24]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] f;
        e = 8'(100 + $urandom_range(0, 49));
        f = 23'($urandom);
        return {1'b0, e, f};
    endfunction

    function automatic int ref_grant(logic [N-1:0] v);
`ifdef FP_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    task automatic tick();
        int g;
        bit iss, ret, full;
        logic [N-1:0] e_rr, e_rv;
        logic e_av, e_cr;
        add_c_valid = spur || (!stall && aq.size() > 0 && aq[0].t <= cyc);
        add_c = (aq.size() > 0) ? aq[0].r : 32'hDEAD_BEEF;
        #1;
        s_rr = req_ready; s_rv = res_valid; s_av = add_valid;
        s_cr = add_c_ready; s_busy = busy; s_out = outstanding;
        s_rc = res_c;
        if (!rst_n) begin
            aq.delete(); tagq.delete(); resq.delete(); rr = 0;
        end
        e_rr = '0; e_rv = '0; e_av = 1'b0; e_cr = 1'b0;
        iss = 1'b0; ret = 1'b0; g = -1;
        if (rst_n) begin
            g    = ref_grant(req_valid);
            full = (tagq.size() == M);
            e_av = (g >= 0) && !full;
            iss  = e_av && add_ready;
            if (iss) e_rr[g] = 1'b1;
            if (tagq.size() > 0) begin
                e_cr = res_ready[tagq[0]];
                if (add_c_valid) e_rv[tagq[0]] = 1'b1;
                ret = add_c_valid && e_cr;
            end
        end
        chk("req_ready", 64'(s_rr), 64'(e_rr));
        chk("add_valid", 64'(s_av), 64'(e_av));
        chk("add_c_ready", 64'(s_cr), 64'(e_cr));
        chk("res_valid", 64'(s_rv), 64'(e_rv));
        chk("outstanding", 64'(s_out), 64'(tagq.size()));
        chk("busy", 64'(s_busy), 64'(tagq.size() != 0));
        if (e_av) begin
            chk("add_a", 64'(add_a), 64'(req_a[32*g +: 32]));
            chk("add_b", 64'(add_b), 64'(req_b[32*g +: 32]));
        end
        if (ret) begin
            chk("res_c", 64'(s_rc), 64'(resq[0]));
            void'(tagq.pop_front());
            void'(resq.pop_front());
            void'(aq.pop_front());
        end
        s_iss = iss ? g : -1;
        if (iss) begin
            aop_t op;
            op.r = fadd(req_a[32*g +: 32], req_b[32*g +: 32]);
            op.t = cyc + LAT;
            aq.push_back(op);
            tagq.push_back(g);
            resq.push_back(op.r);
            rr = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        req_valid = '0; stall = 1'b0; spur = 1'b0; res_ready = '1;
        for (int i = 0; i < 60 && tagq.size() > 0; i++) tick();
        chk("drain_outstanding", 64'(outstanding), 64'd0);
    endtask

    task automatic new_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = rnd_fp();
            req_b[32*i +: 32] = rnd_fp();
        end
    endtask

    vec_t vt[7];
    int   grants[$];
    int   n;

    initial begin
        checks = 0; errors = 0; cyc = 0; rr = 0;
        rst_n = 1'b0; req_valid = '0; add_ready = 1'b0;
        res_ready = '1; add_c = '0; add_c_valid = 1'b0;
        stall = 1'b0; spur = 1'b0;
        new_ops();
        @(negedge clk);
        tick();
        rst_n = 1'b1;

`ifndef FP_ARB_FIXED_PRIO_EN
        // v, ar, spur, e_rr, e_av, e_cr, e_rv, e_out
        vt[0] = '{4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000, 0};
        vt[1] = '{4'b1010, 0, 0, 4'b0000, 1, 0, 4'b0000, 0};
        vt[2] = '{4'b1010, 1, 0, 4'b0010, 1, 0, 4'b0000, 0};
        vt[3] = '{4'b1011, 1, 0, 4'b1000, 1, 1, 4'b0000, 1};
        vt[4] = '{4'b0110, 1, 0, 4'b0010, 1, 1, 4'b0000, 2};
        vt[5] = '{4'b0001, 1, 0, 4'b0001, 1, 1, 4'b0000, 3};
        vt[6] = '{4'b1111, 1, 0, 4'b0000, 0, 1, 4'b0000, 4};
        stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid = vt[i].v; add_ready = vt[i].ar; spur = vt[i].spur;
            tick();
            chk($sformatf("vec%0d_req_ready", i), 64'(s_rr), 64'(vt[i].e_rr));
            chk($sformatf("vec%0d_add_valid", i), 64'(s_av), 64'(vt[i].e_av));
            chk($sformatf("vec%0d_add_c_ready", i), 64'(s_cr), 64'(vt[i].e_cr));
            chk($sformatf("vec%0d_res_valid", i), 64'(s_rv), 64'(vt[i].e_rv));
            chk($sformatf("vec%0d_outstanding", i), 64'(s_out), 64'(vt[i].e_out));
        end
        chk("full_busy", 64'(s_busy), 64'd1);
        spur = 1'b0;
`endif
        drain();

        // Full FIFO with the head requester refusing its result.
        stall = 1'b1; req_valid = '1; add_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("fill_outstanding", 64'(outstanding), 64'd4);
        res_ready = '1;
        res_ready[tagq[0]] = 1'b0;
        stall = 1'b0;
        n = 0;
        while (!add_c_valid && n < 10) begin
            tick(); n++;
        end
        chk("head_result_arrived", 64'(n < 10), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_add_c_ready", 64'(s_cr), 64'd0);
            chk("hold_add_valid", 64'(s_av), 64'd0);
            chk("hold_out", 64'(s_out), 64'd4);
        end
        res_ready = '1;
        tick();
        chk("release_pop", 64'(s_cr), 64'd1);
        tick();
        chk("one_new_issue", 64'($countones(s_rr)), 64'd1);
        drain();

        // Reset with three operations in flight.
        stall = 1'b1; req_valid = '1; add_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_reset_out", 64'(outstanding), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_add_valid", 64'(add_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_add_c_ready", 64'(add_c_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        tick();
        rst_n = 1'b1; stall = 1'b0;
        tick();
        chk("rst_restart_grant", 64'(s_rr), 64'd1);

`ifndef FP_ARB_FIXED_PRIO_EN
        // Continuous requests rotate 0,1,2,3,...
        grants.delete();
        grants.push_back(0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_iss >= 0) grants.push_back(s_iss);
        end
        chk("rr_issue_count", 64'(grants.size() >= 8), 64'd1);
        for (int i = 0; i < grants.size(); i++)
            chk("rr_order", 64'(grants[i]), 64'(i % N));
`else
        // Fixed priority: requester 3 never wins against requester 1.
        req_valid = 4'b1010;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("prio_no_req3", 64'(s_rr[3]), 64'd0);
            if (s_rr[1]) n++;
        end
        chk("prio_req1_count", 64'(n >= 8), 64'd1);
`endif
        drain();

        // Requester 0 alone, 1.0 + 2.0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000;
        req_valid = 4'b0001; add_ready = 1'b1;
        tick();
        chk("single_issue", 64'(s_rr), 64'd1);
        req_valid = '0;
        n = 0;
        do begin
            tick(); n++;
        end while (s_rv == '0 && n < 12);
        chk("single_latency", 64'(n), 64'(LAT));
        chk("single_res_valid", 64'(s_rv), 64'b0001);
        chk("single_res_c", 64'(s_rc), 64'h4040_0000);
        tick();
        chk("single_out_zero", 64'(s_out), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            req_valid = N'($urandom);
            add_ready = ($urandom_range(0, 3) != 0);
            res_ready = N'($urandom) | N'($urandom);
            stall     = ($urandom_range(0, 7) == 0);
            spur      = (tagq.size() == 0) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) new_ops();
            tick();
        end
        spur = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FP32 adder, range 2..8.
REQ-002 Parameter MAX_OUT, default 4: maximum outstanding adder operations; power of two, range 2..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_a  input  32*NUM_REQ  operand a per requester; slice i is bits [32i+31:32i].
REQ-006 req_b  input  32*NUM_REQ  operand b per requester, same slicing.
REQ-007 req_valid  input  NUM_REQ  request valid per requester.
REQ-008 req_ready  output  NUM_REQ  request accepted per requester.
REQ-009 add_a, add_b  output  32 each  operands driven to the shared adder.
REQ-010 add_valid  output  1  operand pair valid toward the adder.
REQ-011 add_ready  input  1  adder accepts the operand pair.
REQ-012 add_c  input  32  adder result; add_c_valid input 1; add_c_ready output 1.
REQ-013 res_c  output  32  result broadcast to all requesters.
REQ-014 res_valid  output  NUM_REQ  one-hot result valid, addressed to the issuing requester.
REQ-015 res_ready  input  NUM_REQ  per-requester result acceptance.
REQ-016 busy  output  1  high while any operation is outstanding; outstanding  output  $clog2(MAX_OUT)+1  count.

Function
REQ-017 A transfer on any channel occurs only in a cycle where its valid and ready are both high.
REQ-018 The adder returns results in issue order; the block tracks issue order with a requester-ID tag FIFO of depth MAX_OUT.
REQ-019 Grant: round-robin among asserted req_valid, starting search at pointer rr_ptr; grant is combinational and one-hot.
REQ-020 add_valid = (any req_valid) AND NOT fifo_full; add_a/add_b = slices of the granted requester; zero added latency.
REQ-021 req_ready[i] = grant[i] AND add_ready AND NOT fifo_full; all other req_ready bits low.
REQ-022 On an issue transfer: push granted ID into tag FIFO, rr_ptr <= (granted ID + 1) mod NUM_REQ; rr_ptr unchanged otherwise.
REQ-023 add_c_ready = NOT fifo_empty AND res_ready[head ID]; res_valid[head ID] = add_c_valid AND NOT fifo_empty; res_c = add_c.
REQ-024 On a result transfer, pop the tag FIFO; add_c_valid while fifo_empty is ignored (add_c_ready low, no res_valid).
REQ-025 Simultaneous issue and retire: push and pop both occur, outstanding unchanged; full blocks issue even if a retire occurs the same cycle (no bypass).
REQ-026 outstanding = FIFO occupancy, 0..MAX_OUT; busy = (outstanding != 0).
REQ-027 A requester whose req_valid drops before acceptance loses its turn without affecting rr_ptr.

Reset
REQ-028 While rst_n low: FIFO empty, rr_ptr = 0, outstanding = 0, busy = 0, add_valid = 0, add_c_ready = 0, req_ready = 0, res_valid = 0.
REQ-029 Reset mid-operation discards all outstanding tags; the adder is reset from the same rst_n, so no stale result is routed.

Configuration
REQ-030 Macro FP_ARB_FIXED_PRIO_EN: when defined, grant is fixed priority, lowest index wins, rr_ptr is removed; when undefined, round-robin per REQ-019/REQ-022.

Verification
REQ-031 Requester 0 alone, a=0x3F800000, b=0x40000000, adder latency 3 -> res_valid=4'b0001, res_c=0x40400000, outstanding returns 0.
REQ-032 All four valid continuously, add_ready=1 -> grants 0,1,2,3,0,... each result routed to matching res_valid bit in order.
REQ-033 MAX_OUT=4, add_c_valid held low -> after 4 issues add_valid=0, all req_ready=0, outstanding=4, busy=1.
REQ-034 Full FIFO, res_ready[head]=0 for 5 cycles -> add_c_ready=0, result held; then res_ready=1 -> pop, one new issue next cycle.
REQ-035 rst_n pulsed low with 3 outstanding -> outputs per REQ-028 immediately, grant restarts at requester 0.
REQ-036 FP_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 valid continuously -> requester 1 granted every cycle, requester 3 starved.
